// File: rtl/led_mux_sequencer.sv
// led_mux_sequencer
//
// Time-multiplexes the RED and IR LEDs of the pulse-oximeter front end. Each
// phase drives one LED, applies that channel's DC-compensation code and PGA
// gain, waits SETTLE_CYC cycles for the analog chain to settle, then averages
// 2^AVG_LOG2 ADC samples. The average leaves on a valid/ready output.
//
// Optional feature: define AMBIENT_SUB_EN to add a DARK phase (both LEDs off)
// before every IR phase. IR and RED results then have the dark average
// subtracted, saturating at 0.
//
// Parameters:
//   SETTLE_CYC  settling cycles per phase, 1..255
//   AVG_LOG2    log2 of samples averaged per phase, 0..4
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   enable               run the sequence; low returns to idle
//   dc_ir/dc_red         per-channel DC-compensation codes (sampled at phase start)
//   pga_ir/pga_red       per-channel PGA gains (sampled at phase start)
//   adc                  unsigned ADC sample, one per clk
//   led_ir/led_red       LED drives
//   dc_comp/pga_gain     settings applied to the analog front end
//   out_valid/out_ready  result handshake
//   out_ch/out_data      result channel (0 = IR, 1 = RED) and averaged value
//   overrun              sticky: an unaccepted result was overwritten
module led_mux_sequencer #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] dc_ir,
    input  logic [6:0] dc_red,
    input  logic [3:0] pga_ir,
    input  logic [3:0] pga_red,
    input  logic [7:0] adc,
    output logic       led_ir,
    output logic       led_red,
    output logic [6:0] dc_comp,
    output logic [3:0] pga_gain,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_ch,
    output logic [7:0] out_data,
    output logic       overrun
);

    localparam int unsigned NSAMP       = 1 << AVG_LOG2;
    localparam int unsigned AW          = 8 + AVG_LOG2;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]  SAMPLE_LAST = 8'(NSAMP - 1);
    localparam logic [6:0]  DC_IDLE     = 7'd64;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StIrSettle  = 3'd1,
        StIrSample  = 3'd2,
        StRedSettle = 3'd3,
        StRedSample = 3'd4
`ifdef AMBIENT_SUB_EN
        ,
        StDarkSettle = 3'd5,
        StDarkSample = 3'd6
`endif
    } state_e;

`ifdef AMBIENT_SUB_EN
    localparam state_e FIRST_SETTLE = StDarkSettle;
    localparam state_e FIRST_SAMPLE = StDarkSample;
`else
    localparam state_e FIRST_SETTLE = StIrSettle;
    localparam state_e FIRST_SAMPLE = StIrSample;
`endif

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            led_ir_q, led_ir_d, led_red_q, led_red_d;
    logic [6:0]      dc_q, dc_d;
    logic [3:0]      pga_q, pga_d;
    logic            valid_q, valid_d, ch_q, ch_d, ovr_q, ovr_d;
    logic [7:0]      data_q, data_d;
`ifdef AMBIENT_SUB_EN
    logic [7:0]      dark_q, dark_d;
    logic            load_dark;
`endif

    logic [AW-1:0]   sum;
    logic [7:0]      avg, res_val;
    logic            load_ir, load_red, res_load, res_ch;
    logic            settle_done, sample_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        acc_d     = acc_q;
        led_ir_d  = led_ir_q;
        led_red_d = led_red_q;
        dc_d      = dc_q;
        pga_d     = pga_q;
        load_ir   = 1'b0;
        load_red  = 1'b0;
        res_load  = 1'b0;
        res_ch    = 1'b0;
`ifdef AMBIENT_SUB_EN
        load_dark = 1'b0;
        dark_d    = dark_q;
`endif

        settle_done = (cnt_q == SETTLE_LAST);
        sample_done = (cnt_q == SAMPLE_LAST);
        sum         = acc_q + AW'(adc);
        avg         = 8'(sum >> AVG_LOG2);
`ifdef AMBIENT_SUB_EN
        res_val     = (avg > dark_q) ? (avg - dark_q) : 8'd0;
`else
        res_val     = avg;
`endif

        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            acc_d     = '0;
            led_ir_d  = 1'b0;
            led_red_d = 1'b0;
            dc_d      = DC_IDLE;
            pga_d     = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // The enable edge counts as the first settle cycle, so the first
                    // result lands SETTLE_CYC+N-1 edges after enable is seen.
                    acc_d = '0;
                    if (SETTLE_CYC > 1) begin
                        state_d = FIRST_SETTLE;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = FIRST_SAMPLE;
                        cnt_d   = '0;
                    end
`ifdef AMBIENT_SUB_EN
                    load_dark = 1'b1;
`else
                    load_ir   = 1'b1;
`endif
                end
                StIrSettle: begin
                    if (settle_done) begin
                        state_d = StIrSample;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
                StIrSample: begin
                    acc_d = sum;
                    if (sample_done) begin
                        state_d  = StRedSettle;
                        cnt_d    = '0;
                        load_red = 1'b1;
                        res_load = 1'b1;
                        res_ch   = 1'b0;
                    end
                end
                StRedSettle: begin
                    if (settle_done) begin
                        state_d = StRedSample;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
                StRedSample: begin
                    acc_d = sum;
                    if (sample_done) begin
                        cnt_d    = '0;
                        res_load = 1'b1;
                        res_ch   = 1'b1;
`ifdef AMBIENT_SUB_EN
                        state_d   = StDarkSettle;
                        load_dark = 1'b1;
`else
                        state_d   = StIrSettle;
                        load_ir   = 1'b1;
`endif
                    end
                end
`ifdef AMBIENT_SUB_EN
                StDarkSettle: begin
                    if (settle_done) begin
                        state_d = StDarkSample;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
                StDarkSample: begin
                    acc_d = sum;
                    if (sample_done) begin
                        state_d = StIrSettle;
                        cnt_d   = '0;
                        dark_d  = avg;
                        load_ir = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        // Phase-entry settings: LED swap and DAC/PGA load share one edge.
        if (load_ir) begin
            led_ir_d  = 1'b1;
            led_red_d = 1'b0;
            dc_d      = dc_ir;
            pga_d     = pga_ir;
        end
        if (load_red) begin
            led_ir_d  = 1'b0;
            led_red_d = 1'b1;
            dc_d      = dc_red;
            pga_d     = pga_red;
        end
`ifdef AMBIENT_SUB_EN
        if (load_dark) begin
            led_ir_d  = 1'b0;
            led_red_d = 1'b0;
            dc_d      = dc_ir;
            pga_d     = pga_ir;
        end
`endif

        // Output register: a new result wins over acceptance.
        valid_d = valid_q;
        ch_d    = ch_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (res_load) begin
            valid_d = 1'b1;
            ch_d    = res_ch;
            data_d  = res_val;
            if (valid_q && !out_ready) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (!enable) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            led_ir_q  <= 1'b0;
            led_red_q <= 1'b0;
            dc_q      <= DC_IDLE;
            pga_q     <= 4'd0;
            valid_q   <= 1'b0;
            ch_q      <= 1'b0;
            data_q    <= 8'd0;
            ovr_q     <= 1'b0;
`ifdef AMBIENT_SUB_EN
            dark_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            led_ir_q  <= led_ir_d;
            led_red_q <= led_red_d;
            dc_q      <= dc_d;
            pga_q     <= pga_d;
            valid_q   <= valid_d;
            ch_q      <= ch_d;
            data_q    <= data_d;
            ovr_q     <= ovr_d;
`ifdef AMBIENT_SUB_EN
            dark_q    <= dark_d;
`endif
        end
    end

    assign led_ir    = led_ir_q;
    assign led_red   = led_red_q;
    assign dc_comp   = dc_q;
    assign pga_gain  = pga_q;
    assign out_valid = valid_q;
    assign out_ch    = ch_q;
    assign out_data  = data_q;
    assign overrun   = ovr_q;

endmodule
